pieo_dequeue_ctrl: RTL and testbench
====================================

// Module: pieo_dequeue_ctrl
// PURPOSE
//  Extract-side client of the PIEO list: the counterpart of the enqueue path. On each timeslot tick it
//  issues up to MAX_DEQ_PER_SLOT dequeue requests, presenting the bucket-eligibility bitmap as curr_time.
//  It filters returned SublistElements and buffers eligible ones in an output FIFO for the cell scheduler.
//  It also reports per-slot completion and error status.
// PARAMETERS
//  MAX_DEQ_PER_SLOT  2   max dequeues issued per slot_tick (>=1)
//  FIFO_DEPTH        4   output FIFO entries (power of 2, >=2)
//  TIMEOUT_CYC       16  cycles to wait for pieo_deq_valid before abandoning the slot
//  CNT_W             16  width of statistics counters
// PORTS
//  clk               in   1              clock
//  rst               in   1              async active-high reset
//  slot_tick         in   1              1-cycle pulse: timeslot start
//  eligible_bitmap   in   TIME_LOG       bit b=1 -> bucket b eligible; bit NULL_BUCKET always 0
//  pieo_ready        in   1              PIEO can accept a dequeue this cycle
//  pieo_deq_start    out  1              1-cycle dequeue request pulse
//  pieo_curr_time    out  TIME_LOG       bitmap latched at slot_tick, held for whole slot
//  pieo_deq_valid    in   1              PIEO response strobe
//  pieo_deq_element  in   SublistElement returned element; send_time==NULL_BUCKET -> nothing eligible
//  out_valid         out  1              FIFO head valid
//  out_ready         in   1              consumer accepts head when out_valid&&out_ready
//  out_element       out  SublistElement FIFO head (first-word fall-through)
//  slot_done         out  1              1-cycle pulse when slot processing ends
//  timeout_err       out  1              sticky: a response timed out
//  overrun_err       out  1              sticky: slot_tick arrived while not IDLE
//  deq_count         out  CNT_W          eligible elements pushed (wraps)
//  miss_count        out  CNT_W          NULL/ineligible responses (wraps)
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, FIFO empty, issued=0, all outputs 0, counters 0, pieo_curr_time=0.
//  FSM: IDLE, REQ, WAIT, DONE.
//   IDLE: slot_tick -> latch eligible_bitmap into pieo_curr_time, issued=0, go REQ.
//   REQ: when pieo_ready && FIFO not full -> pieo_deq_start=1 for exactly that cycle, go WAIT (timer=0).
//        Otherwise stall in REQ with no timeout.
//   WAIT: on pieo_deq_valid, with e=pieo_deq_element:
//     - Ineligible when e.send_time==NULL_BUCKET, e.send_time>=TIME_LOG, or !pieo_curr_time[e.send_time].
//       Then miss_count++ and go DONE.
//     - Else push e to FIFO, deq_count++, issued++. If issued==MAX_DEQ_PER_SLOT go DONE, else go REQ.
//     - Without valid, timer++. On timer==TIMEOUT_CYC-1: set timeout_err, go DONE.
//       A response arriving later is ignored.
//   DONE: slot_done=1 for one cycle, go IDLE.
//  At most one request outstanding; the FIFO slot is reserved at issue, so a push never overflows.
//  pieo_deq_valid outside WAIT is ignored.
//  slot_tick in any state other than IDLE sets overrun_err and is otherwise dropped (no re-latch).
//   slot_tick coincident with DONE counts as an overrun.
//  FIFO: simultaneous push and pop is legal at any occupancy, count unchanged.
//   Pointers wrap modulo FIFO_DEPTH. Pop on empty is impossible (out_valid=0).
//  Latency: slot_tick -> pieo_deq_start is 1 cycle min. pieo_deq_valid -> out_valid is 1 cycle
//   (registered push, FIFO previously empty).
//  Sticky errors clear only on rst. Counters wrap at 2^CNT_W.
// STRUCTURE
//  Uses pieo_datatypes (SublistElement, TIME_LOG, NULL_BUCKET).
//  New package entries: typedef enum {DQ_IDLE,DQ_REQ,DQ_WAIT,DQ_DONE} DeqState_t.
//  Sub-module pieo_elem_fifo: parameterised FWFT FIFO of SublistElement with push/pop/full/empty/count.
// TESTING
//  1 Reset mid-WAIT:
//    rst asserted -> all outputs 0 next cycle, FIFO empty, state IDLE.
//  2 Two eligible elements:
//    bitmap=12'h006, slot_tick; PIEO returns send_time=1 then 2
//    -> 2 start pulses, FIFO holds both in order, deq_count=2, slot_done once.
//  3 NULL response:
//    first response send_time=11 (NULL_BUCKET) -> miss_count=1, no push, slot_done after 1 request.
//  4 Ineligible and out-of-range:
//    bitmap=12'h002, response send_time=3 -> miss; response send_time=40 -> miss, no push.
//  5 Backpressure:
//    out_ready=0 over 2 slots, FIFO_DEPTH=4 -> fills to 4, then REQ stalls with no start pulse.
//    out_ready=1 -> request resumes next cycle.
//  6 Timeout and overrun:
//    no valid for 16 cycles -> timeout_err=1, slot_done.
//    slot_tick during WAIT -> overrun_err=1, curr_time unchanged.

Source files
------------

// File: rtl/pieo_dequeue_ctrl_pkg.sv
// Shared PIEO element types plus the dequeue controller's state encoding and
// the eligibility test applied to elements returned by the PIEO list.
package pieo_datatypes;
  localparam int TIME_LOG    = 12;
  localparam int NULL_BUCKET = TIME_LOG - 1;
  localparam int ID_W        = 16;
  localparam int SEND_TIME_W = 8;

  typedef struct packed {
    logic [ID_W-1:0]        id;
    logic [SEND_TIME_W-1:0] send_time;
  } SublistElement;
endpackage

package pieo_dequeue_ctrl_pkg;
  import pieo_datatypes::*;

  typedef enum logic [1:0] {DQ_IDLE, DQ_REQ, DQ_WAIT, DQ_DONE} DeqState_t;

  // Out-of-range and NULL buckets never match a bitmap bit, so they fall out as ineligible.
  function automatic logic elem_eligible(input logic [TIME_LOG-1:0] bitmap,
                                         input SublistElement e);
    logic ok;
    ok = 1'b0;
    for (int b = 0; b < TIME_LOG; b++) begin
      if (b != NULL_BUCKET && int'(e.send_time) == b) ok = bitmap[b];
    end
    return ok;
  endfunction
endpackage

// File: rtl/pieo_dequeue_ctrl_elem_fifo.sv
// First-word fall-through FIFO of SublistElement; the head is forced to zero while empty.
module pieo_elem_fifo
  import pieo_datatypes::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  SublistElement push_elem,
  input  logic          pop,
  output SublistElement head_elem,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  SublistElement mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_elem;
  end

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign head_elem = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/pieo_dequeue_ctrl.sv
// Per-timeslot dequeue client of the PIEO list: issues up to MAX_DEQ_PER_SLOT
// requests, filters returned elements by the latched bitmap and buffers eligible ones.
module pieo_dequeue_ctrl
  import pieo_datatypes::*;
  import pieo_dequeue_ctrl_pkg::*;
#(
  parameter int MAX_DEQ_PER_SLOT = 2,
  parameter int FIFO_DEPTH       = 4,
  parameter int TIMEOUT_CYC      = 16,
  parameter int CNT_W            = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                slot_tick,
  input  logic [TIME_LOG-1:0] eligible_bitmap,
  input  logic                pieo_ready,
  output logic                pieo_deq_start,
  output logic [TIME_LOG-1:0] pieo_curr_time,
  input  logic                pieo_deq_valid,
  input  SublistElement       pieo_deq_element,
  output logic                out_valid,
  input  logic                out_ready,
  output SublistElement       out_element,
  output logic                slot_done,
  output logic                timeout_err,
  output logic                overrun_err,
  output logic [CNT_W-1:0]    deq_count,
  output logic [CNT_W-1:0]    miss_count
);
  localparam int IW  = $clog2(MAX_DEQ_PER_SLOT + 1);
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  DeqState_t      state, state_nx;
  logic [IW-1:0]  issued;
  logic [TW-1:0]  timer;
  logic           fifo_full, fifo_empty;
  logic [FCW-1:0] fifo_count_unused;
  logic           elig, push, pop, miss, timeout_hit;

  assign elig      = elem_eligible(pieo_curr_time, pieo_deq_element);
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DQ_IDLE;
    else     state <= state_nx;
  end

  // Issuing only with a free FIFO entry reserves room for the single outstanding response.
  always_comb begin
    state_nx       = state;
    pieo_deq_start = 1'b0;
    slot_done      = 1'b0;
    push           = 1'b0;
    miss           = 1'b0;
    timeout_hit    = 1'b0;
    case (state)
      DQ_IDLE: if (slot_tick) state_nx = DQ_REQ;
      DQ_REQ: begin
        if (pieo_ready && !fifo_full) begin
          pieo_deq_start = 1'b1;
          state_nx       = DQ_WAIT;
        end
      end
      DQ_WAIT: begin
        if (pieo_deq_valid) begin
          if (elig) begin
            push     = 1'b1;
            state_nx = (issued == IW'(MAX_DEQ_PER_SLOT - 1)) ? DQ_DONE : DQ_REQ;
          end else begin
            miss     = 1'b1;
            state_nx = DQ_DONE;
          end
        end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
          timeout_hit = 1'b1;
          state_nx    = DQ_DONE;
        end
      end
      DQ_DONE: begin
        slot_done = 1'b1;
        state_nx  = DQ_IDLE;
      end
      default: state_nx = DQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued         <= '0;
      timer          <= '0;
      pieo_curr_time <= '0;
      timeout_err    <= 1'b0;
      overrun_err    <= 1'b0;
      deq_count      <= '0;
      miss_count     <= '0;
    end else begin
      if (state == DQ_IDLE && slot_tick) begin
        pieo_curr_time <= eligible_bitmap;
        issued         <= '0;
      end
      if (slot_tick && state != DQ_IDLE) overrun_err <= 1'b1;
      if (pieo_deq_start) timer <= '0;
      else if (state == DQ_WAIT && !pieo_deq_valid) timer <= timer + TW'(1);
      if (push) begin
        issued    <= issued + IW'(1);
        deq_count <= deq_count + CNT_W'(1);
      end
      if (miss)        miss_count  <= miss_count + CNT_W'(1);
      if (timeout_hit) timeout_err <= 1'b1;
    end
  end

  pieo_elem_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_elem (pieo_deq_element),
    .pop       (pop),
    .head_elem (out_element),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count_unused)
  );
endmodule

// File: tb/tb_pieo_dequeue_ctrl.sv
// Bench for pieo_dequeue_ctrl: directed slot scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of slot progress and the output queue.
module tb_pieo_dequeue_ctrl;
  import pieo_datatypes::*;

  localparam int MAXD  = 2;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                slot_tick = 1'b0;
  logic [TIME_LOG-1:0] eligible_bitmap = '0;
  logic                pieo_ready = 1'b0;
  logic                pieo_deq_start;
  logic [TIME_LOG-1:0] pieo_curr_time;
  logic                pieo_deq_valid = 1'b0;
  SublistElement       pieo_deq_element = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  SublistElement       out_element;
  logic                slot_done;
  logic                timeout_err;
  logic                overrun_err;
  logic [15:0]         deq_count;
  logic [15:0]         miss_count;

  always #5 clk = ~clk;

  pieo_dequeue_ctrl #(
    .MAX_DEQ_PER_SLOT (MAXD),
    .FIFO_DEPTH       (DEPTH),
    .TIMEOUT_CYC      (TMO),
    .CNT_W            (16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .slot_tick        (slot_tick),
    .eligible_bitmap  (eligible_bitmap),
    .pieo_ready       (pieo_ready),
    .pieo_deq_start   (pieo_deq_start),
    .pieo_curr_time   (pieo_curr_time),
    .pieo_deq_valid   (pieo_deq_valid),
    .pieo_deq_element (pieo_deq_element),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_element      (out_element),
    .slot_done        (slot_done),
    .timeout_err      (timeout_err),
    .overrun_err      (overrun_err),
    .deq_count        (deq_count),
    .miss_count       (miss_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: slot progress flags, a queue for the FIFO, plain counters.
  SublistElement m_q[$];
  logic [TIME_LOG-1:0] m_curr;
  bit m_need_req, m_wait, m_fin, m_tmo, m_ovr;
  int m_grant, m_age;
  logic [15:0] m_deq, m_miss;

  // Responder and stimulus controls.
  int resp_timer = -1;
  int forced_delay = 0;
  bit rand_mode = 0;
  SublistElement script[$];
  int starts_seen = 0;
  int dones_seen = 0;
  bit d_tick = 0;
  logic [TIME_LOG-1:0] d_bitmap = '0;
  bit d_ready = 0;
  bit d_oready = 0;

  function automatic bit ref_eligible(logic [TIME_LOG-1:0] bm, SublistElement e);
    int st;
    st = int'(e.send_time);
    if (st >= TIME_LOG || st == NULL_BUCKET) return 1'b0;
    return ((bm >> st) & 1) != 0;
  endfunction

  function automatic SublistElement next_elem();
    SublistElement e;
    if (script.size() > 0) begin
      e = script.pop_front();
    end else begin
      e.id = 16'($urandom);
      e.send_time = ($urandom_range(0, 9) == 0) ? 8'd40 : 8'($urandom_range(0, 11));
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_curr = '0;
    m_need_req = 0; m_wait = 0; m_fin = 0; m_tmo = 0; m_ovr = 0;
    m_grant = 0; m_age = 0;
    m_deq = '0; m_miss = '0;
  endtask

  task automatic reset_step();
    @(posedge clk); #1;
    rst = 1'b1;
    slot_tick = 0; pieo_ready = 0; out_ready = 0; pieo_deq_valid = 0;
    pieo_deq_element = '0; eligible_bitmap = '0;
    d_tick = 0; d_ready = 0; d_oready = 0;
    model_reset();
    resp_timer = -1;
    script.delete();
    #4;
    chk("rst_deq_start", 64'(pieo_deq_start), 0);
    chk("rst_slot_done", 64'(slot_done), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_element", 64'(out_element), 0);
    chk("rst_curr_time", 64'(pieo_curr_time), 0);
    chk("rst_timeout_err", 64'(timeout_err), 0);
    chk("rst_overrun_err", 64'(overrun_err), 0);
    chk("rst_deq_count", 64'(deq_count), 0);
    chk("rst_miss_count", 64'(miss_count), 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic step();
    bit busy, exp_start, exp_valid, pop;
    SublistElement exp_el;
    @(posedge clk); #1;
    slot_tick = d_tick; eligible_bitmap = d_bitmap;
    pieo_ready = d_ready; out_ready = d_oready;
    pieo_deq_valid = 1'b0;
    pieo_deq_element = 24'($urandom);
    if (resp_timer > 0) begin
      resp_timer--;
      if (resp_timer == 0) begin
        pieo_deq_valid = 1'b1;
        pieo_deq_element = next_elem();
        resp_timer = -1;
      end
    end else if (rand_mode && $urandom_range(0, 19) == 0) begin
      pieo_deq_valid = 1'b1;
      pieo_deq_element = next_elem();
    end
    #4;
    exp_start = m_need_req && pieo_ready && (m_q.size() < DEPTH);
    exp_valid = m_q.size() > 0;
    exp_el = exp_valid ? m_q[0] : '0;
    chk("deq_start", 64'(pieo_deq_start), 64'(exp_start));
    chk("slot_done", 64'(slot_done), 64'(m_fin));
    chk("out_valid", 64'(out_valid), 64'(exp_valid));
    chk("out_element", 64'(out_element), 64'(exp_el));
    chk("curr_time", 64'(pieo_curr_time), 64'(m_curr));
    chk("timeout_err", 64'(timeout_err), 64'(m_tmo));
    chk("overrun_err", 64'(overrun_err), 64'(m_ovr));
    chk("deq_count", 64'(deq_count), 64'(m_deq));
    chk("miss_count", 64'(miss_count), 64'(m_miss));
    if (pieo_deq_start) starts_seen++;
    if (slot_done) dones_seen++;
    if (exp_start)
      resp_timer = (forced_delay > 0) ? forced_delay :
                   (($urandom_range(0, 9) == 0) ? 20 : $urandom_range(1, 4));

    pop = exp_valid && out_ready;
    if (pop) void'(m_q.pop_front());
    busy = m_need_req || m_wait || m_fin;
    if (slot_tick && busy) m_ovr = 1;
    if (slot_tick && !busy) begin
      m_curr = eligible_bitmap;
      m_grant = 0;
      m_need_req = 1;
    end else if (exp_start) begin
      m_need_req = 0;
      m_wait = 1;
      m_age = 0;
    end else if (m_wait) begin
      if (pieo_deq_valid) begin
        m_wait = 0;
        if (ref_eligible(m_curr, pieo_deq_element)) begin
          m_q.push_back(pieo_deq_element);
          m_deq++;
          m_grant++;
          if (m_grant == MAXD) m_fin = 1;
          else m_need_req = 1;
        end else begin
          m_miss++;
          m_fin = 1;
        end
      end else if (m_age == TMO - 1) begin
        m_wait = 0;
        m_tmo = 1;
        m_fin = 1;
      end else begin
        m_age++;
      end
    end else if (m_fin) begin
      m_fin = 0;
    end
  endtask

  task automatic tick_slot(input logic [TIME_LOG-1:0] bm);
    d_tick = 1; d_bitmap = bm;
    step();
    d_tick = 0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    reset_step();

    // Reset while waiting on a response
    d_ready = 1; forced_delay = 100;
    tick_slot(12'h006);
    run(3);
    reset_step();

    // Two eligible elements, kept in order
    forced_delay = 2; d_ready = 1; d_oready = 0;
    script.push_back('{id: 16'hA1, send_time: 8'd1});
    script.push_back('{id: 16'hB2, send_time: 8'd2});
    starts_seen = 0; dones_seen = 0;
    tick_slot(12'h006);
    run(12);
    chk("t2_starts", 64'(starts_seen), 2);
    chk("t2_dones", 64'(dones_seen), 1);
    chk("t2_deq_count", 64'(deq_count), 2);
    chk("t2_head_id", 64'(out_element.id), 64'h00A1);
    d_oready = 1; step(); d_oready = 0; step();
    chk("t2_second_id", 64'(out_element.id), 64'h00B2);

    // NULL response
    reset_step();
    d_ready = 1;
    script.push_back('{id: 16'h0033, send_time: 8'd11});
    starts_seen = 0; dones_seen = 0;
    tick_slot(12'h006);
    run(8);
    chk("t3_miss_count", 64'(miss_count), 1);
    chk("t3_deq_count", 64'(deq_count), 0);
    chk("t3_starts", 64'(starts_seen), 1);
    chk("t3_dones", 64'(dones_seen), 1);
    chk("t3_out_valid", 64'(out_valid), 0);

    // Ineligible bucket, then out-of-range bucket
    script.push_back('{id: 16'h0044, send_time: 8'd3});
    tick_slot(12'h002);
    run(8);
    script.push_back('{id: 16'h0055, send_time: 8'd40});
    tick_slot(12'h002);
    run(8);
    chk("t4_miss_count", 64'(miss_count), 3);
    chk("t4_deq_count", 64'(deq_count), 0);

    // Backpressure fills the FIFO, then REQ stalls
    reset_step();
    d_ready = 1; d_oready = 0;
    for (int i = 0; i < 5; i++)
      script.push_back('{id: 16'(16'h0100 + i), send_time: 8'((i % 2) + 1)});
    tick_slot(12'h006);
    run(10);
    tick_slot(12'h006);
    run(10);
    starts_seen = 0;
    tick_slot(12'h006);
    run(5);
    chk("t5_stall_starts", 64'(starts_seen), 0);
    chk("t5_deq_count", 64'(deq_count), 4);
    chk("t5_head_id", 64'(out_element.id), 64'h0100);
    d_oready = 1; step(); d_oready = 0;
    step();
    chk("t5_resume_starts", 64'(starts_seen), 1);
    run(6);

    // Timeout, and a tick during WAIT
    reset_step();
    d_ready = 1; forced_delay = 100; dones_seen = 0;
    tick_slot(12'h006);
    run(3);
    tick_slot(12'h7FF);
    run(20);
    chk("t6_overrun_err", 64'(overrun_err), 1);
    chk("t6_curr_time", 64'(pieo_curr_time), 64'h006);
    chk("t6_timeout_err", 64'(timeout_err), 1);
    chk("t6_dones", 64'(dones_seen), 1);
    forced_delay = 0;

    // Randomized traffic
    reset_step();
    rand_mode = 1;
    repeat (3000) begin
      d_tick = ($urandom_range(0, 5) == 0);
      d_bitmap = 12'($urandom) & 12'h7FF;
      d_ready = ($urandom_range(0, 3) != 0);
      d_oready = ($urandom_range(0, 4) < 3);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
